icache_port: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache on memory port 0, between the cpu

---
 rtl/icache_port_pkg.sv | 20 ++
 rtl/icache_store.sv | 50 +++++
 rtl/icache_port.sv | 163 ++++++++++++++++
 tb/tb_icache_port.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_port_pkg.sv
// Shared encodings for the port-0 instruction cache: memory request flags and FSM states.
package icache_port_pkg;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ICP_IDLE  = 2'b00,
        ICP_MISS  = 2'b01,
        ICP_WRITE = 2'b10,
        ICP_RESP  = 2'b11
    } icp_state_t;

    // Memory reads are always word aligned; the byte offset is only meaningful for writes.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays of the direct-mapped cache: async lookup, sync fill, invalidate port.
module icache_store
    import icache_port_pkg::*;
#(
    parameter int INDEX_BIT = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BIT-1:0]   rd_idx,
    output logic                   rd_valid,
    output logic [29-INDEX_BIT:0]  rd_tag,
    output logic [31:0]            rd_data,
    input  logic                   fill_en,
    input  logic [INDEX_BIT-1:0]   fill_idx,
    input  logic [29-INDEX_BIT:0]  fill_tag,
    input  logic [31:0]            fill_data,
    input  logic                   inv_en,
    input  logic [INDEX_BIT-1:0]   inv_idx
);

    localparam int LINES = 1 << INDEX_BIT;
    localparam int TAG_W = 30 - INDEX_BIT;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Valid bits: cleared asynchronously by reset, set on fill, cleared on a write hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (fill_en) valid_q[fill_idx] <= 1'b1;
            if (inv_en)  valid_q[inv_idx]  <= 1'b0;
        end
    end

    // Tag and data payload: only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/icache_port.sv
// Port-0 instruction cache front end: hit/miss FSM, held memory request, response latch.
module icache_port
    import icache_port_pkg::*;
#(
    parameter int INDEX_BIT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cpu_rw_flag_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_w_data_i,
    input  logic [3:0]  cpu_w_mask_i,
    output logic [31:0] cpu_r_data_o,
    output logic        cpu_busy_o,
    output logic        cpu_done_o,
    output logic [1:0]  mem_rw_flag_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_w_data_o,
    output logic [3:0]  mem_w_mask_o,
    input  logic [31:0] mem_r_data_i,
    input  logic        mem_busy_i,
    input  logic        mem_done_i
);

    localparam int TAG_W = 30 - INDEX_BIT;

    icp_state_t state_q, state_d;

    logic [1:0]  mem_rw_q, mem_rw_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_w_data_q, mem_w_data_d;
    logic [3:0]  mem_w_mask_q, mem_w_mask_d;
    logic        mem_load, mem_clear;
    logic [31:0] r_data_q, r_data_d;
    logic        r_data_load;
    logic        fill_en, inv_en;
    logic        hit;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [31:0]          rd_data;
    logic [INDEX_BIT-1:0] cpu_idx;
    logic [TAG_W-1:0]     cpu_tag;

    // The controller's busy flag needs no handling: the request is simply held until done.
    logic unused_mem_busy;
    assign unused_mem_busy = mem_busy_i;

    assign cpu_idx = cpu_addr_i[INDEX_BIT+1:2];
    assign cpu_tag = cpu_addr_i[31:INDEX_BIT+2];
    assign hit     = rd_valid && (rd_tag == cpu_tag);

    // Fills take idx/tag from the held memory address, so the cpu request may change freely.
    icache_store #(.INDEX_BIT(INDEX_BIT)) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (cpu_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .fill_en   (fill_en),
        .fill_idx  (mem_addr_q[INDEX_BIT+1:2]),
        .fill_tag  (mem_addr_q[31:INDEX_BIT+2]),
        .fill_data (mem_r_data_i),
        .inv_en    (inv_en),
        .inv_idx   (cpu_idx)
    );

    assign cpu_busy_o    = (state_q == ICP_MISS) || (state_q == ICP_WRITE);
    assign cpu_done_o    = (state_q == ICP_RESP);
    assign cpu_r_data_o  = cpu_done_o ? r_data_q : 32'h0;
    assign mem_rw_flag_o = mem_rw_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_w_data_o  = mem_w_data_q;
    assign mem_w_mask_o  = mem_w_mask_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ICP_IDLE;
        else     state_q <= state_d;
    end

    // Next state plus the load/clear strobes for the memory request and response latch.
    always_comb begin
        state_d      = state_q;
        mem_load     = 1'b0;
        mem_clear    = 1'b0;
        mem_rw_d     = RW_IDLE;
        mem_addr_d   = 32'h0;
        mem_w_data_d = 32'h0;
        mem_w_mask_d = 4'h0;
        r_data_load  = 1'b0;
        r_data_d     = 32'h0;
        fill_en      = 1'b0;
        inv_en       = 1'b0;
        unique case (state_q)
            ICP_IDLE: begin
                if (cpu_rw_flag_i == RW_READ) begin
                    if (hit) begin
                        r_data_load = 1'b1;
                        r_data_d    = rd_data;
                        state_d     = ICP_RESP;
                    end else begin
                        mem_load   = 1'b1;
                        mem_rw_d   = RW_READ;
                        mem_addr_d = word_align(cpu_addr_i);
                        state_d    = ICP_MISS;
                    end
                end else if (cpu_rw_flag_i == RW_WRITE) begin
                    mem_load     = 1'b1;
                    mem_rw_d     = RW_WRITE;
                    mem_addr_d   = cpu_addr_i;
                    mem_w_data_d = cpu_w_data_i;
                    mem_w_mask_d = cpu_w_mask_i;
                    inv_en       = hit;
                    state_d      = ICP_WRITE;
                end
            end
            ICP_MISS: begin
                if (mem_done_i) begin
                    fill_en     = 1'b1;
                    r_data_load = 1'b1;
                    r_data_d    = mem_r_data_i;
                    mem_clear   = 1'b1;
                    state_d     = ICP_RESP;
                end
            end
            ICP_WRITE: begin
                if (mem_done_i) begin
                    r_data_load = 1'b1;
                    mem_clear   = 1'b1;
                    state_d     = ICP_RESP;
                end
            end
            ICP_RESP: begin
                state_d = ICP_IDLE;
            end
            default: state_d = ICP_IDLE;
        endcase
    end

    // Memory request registers: loaded on acceptance, held until mem_done_i, then dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rw_q     <= RW_IDLE;
            mem_addr_q   <= 32'h0;
            mem_w_data_q <= 32'h0;
            mem_w_mask_q <= 4'h0;
        end else if (mem_load || mem_clear) begin
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            mem_w_mask_q <= mem_w_mask_d;
        end
    end

    // Response data latch, presented to the cpu during the RESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_data_q <= 32'h0;
        else if (r_data_load) r_data_q <= r_data_d;
    end

endmodule

// File: tb/tb_icache_port.sv
// Self-checking bench for icache_port: directed vector table, corner sequences, random traffic.
module tb_icache_port;
    import icache_port_pkg::*;

    logic        clk, rst;
    logic [1:0]  cpu_rw_flag_i;
    logic [31:0] cpu_addr_i, cpu_w_data_i;
    logic [3:0]  cpu_w_mask_i;
    logic [31:0] cpu_r_data_o;
    logic        cpu_busy_o, cpu_done_o;
    logic [1:0]  mem_rw_flag_o;
    logic [31:0] mem_addr_o, mem_w_data_o;
    logic [3:0]  mem_w_mask_o;
    logic [31:0] mem_r_data_i;
    logic        mem_busy_i, mem_done_i;

    icache_port #(.INDEX_BIT(6)) dut (
        .clk(clk), .rst(rst),
        .cpu_rw_flag_i(cpu_rw_flag_i), .cpu_addr_i(cpu_addr_i),
        .cpu_w_data_i(cpu_w_data_i), .cpu_w_mask_i(cpu_w_mask_i),
        .cpu_r_data_o(cpu_r_data_o), .cpu_busy_o(cpu_busy_o), .cpu_done_o(cpu_done_o),
        .mem_rw_flag_o(mem_rw_flag_o), .mem_addr_o(mem_addr_o),
        .mem_w_data_o(mem_w_data_o), .mem_w_mask_o(mem_w_mask_o),
        .mem_r_data_i(mem_r_data_i), .mem_busy_i(mem_busy_i), .mem_done_i(mem_done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory seen through port 0 (write-through target and miss source).
    logic [31:0] mem_arr [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem_arr.exists(wa)) return mem_arr[wa];
        return wa ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] w;
        w = mem_read(a);
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_arr[{a[31:2], 2'b00}] = w;
    endfunction

    // One cpu transaction with an embedded memory responder answering after lat cycles.
    task automatic run_txn(input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int lat,
                           output int done_k, output int mdone_k, output logic [31:0] rdata,
                           output int nmem, output logic [1:0] mflag, output logic [31:0] maddr,
                           output logic [31:0] mwdata, output logic [3:0] mwmask, output bit proto_ok);
        bit in_req;
        int wcnt;
        done_k = -1; mdone_k = -1; rdata = 0; nmem = 0; mflag = 0; maddr = 0;
        mwdata = 0; mwmask = 0; proto_ok = 1; in_req = 0; wcnt = 0;
        @(negedge clk);
        cpu_rw_flag_i = rw; cpu_addr_i = addr; cpu_w_data_i = wdata; cpu_w_mask_i = mask;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (mem_done_i) begin
                mem_done_i = 1'b0;
                mem_r_data_i = 32'h0;
                in_req = 0;
                if (mem_rw_flag_o != RW_IDLE) proto_ok = 0;
            end else if (mem_rw_flag_o != RW_IDLE) begin
                if (!in_req) begin
                    in_req = 1; nmem++; wcnt = 0;
                    mflag = mem_rw_flag_o; maddr = mem_addr_o;
                    mwdata = mem_w_data_o; mwmask = mem_w_mask_o;
                end else if (mflag != mem_rw_flag_o || maddr != mem_addr_o ||
                             mwdata != mem_w_data_o || mwmask != mem_w_mask_o) begin
                    proto_ok = 0;
                end
                wcnt++;
                if (wcnt >= lat) begin
                    mem_done_i = 1'b1;
                    mdone_k = k;
                    if (mem_rw_flag_o == RW_READ) begin
                        mem_r_data_i = mem_read(mem_addr_o);
                    end else begin
                        mem_r_data_i = 32'hFFFF_FFFF;
                        mem_write(mem_addr_o, mem_w_data_o, mem_w_mask_o);
                    end
                end
            end
            if (cpu_done_o) begin
                done_k = k;
                rdata = cpu_r_data_o;
                cpu_rw_flag_i = RW_IDLE;
                break;
            end
        end
        if (done_k < 0) begin
            cpu_rw_flag_i = RW_IDLE;
            mem_done_i = 1'b0;
            proto_ok = 0;
        end
    endtask

    // exp_mem: 0 = served from cache, 1 = memory read, 2 = memory write.
    task automatic do_and_check(input string name, input logic [1:0] rw, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] mask, input int lat,
                                input int exp_mem, input logic [31:0] exp_data);
        int done_k, mdone_k, nmem;
        logic [31:0] rdata, maddr, mwdata;
        logic [1:0] mflag;
        logic [3:0] mwmask;
        bit proto_ok;
        run_txn(rw, addr, wdata, mask, lat, done_k, mdone_k, rdata, nmem, mflag, maddr,
                mwdata, mwmask, proto_ok);
        check({name, " protocol/timeout"}, 32'(proto_ok), 32'd1);
        check({name, " mem requests"}, nmem, (exp_mem != 0) ? 1 : 0);
        if (exp_mem == 0) begin
            check({name, " hit latency"}, done_k, 1);
        end else begin
            check({name, " mem flag"}, 32'(mflag), (exp_mem == 1) ? 32'(RW_READ) : 32'(RW_WRITE));
            check({name, " mem addr"}, maddr, (exp_mem == 1) ? {addr[31:2], 2'b00} : addr);
            check({name, " done after mem_done"}, done_k, mdone_k + 1);
            if (exp_mem == 2) begin
                check({name, " mem wdata"}, mwdata, wdata);
                check({name, " mem wmask"}, 32'(mwmask), 32'(mask));
            end
        end
        check({name, " rdata"}, rdata, exp_data);
    endtask

    typedef struct {
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          lat;
        int          exp_mem;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, bad, prev;
        bit consec;
        bit mv [int];
        logic [23:0] mt [int];

        vecs[0]  = '{RW_READ,  32'h100, 32'h0,          4'h0, 3, 1, 32'hDEADBEEF};
        vecs[1]  = '{RW_READ,  32'h100, 32'h0,          4'h0, 1, 0, 32'hDEADBEEF};
        vecs[2]  = '{RW_READ,  32'h200, 32'h0,          4'h0, 2, 1, 32'hCAFE0200};
        vecs[3]  = '{RW_READ,  32'h100, 32'h0,          4'h0, 1, 1, 32'hDEADBEEF};
        vecs[4]  = '{RW_READ,  32'h104, 32'h0,          4'h0, 2, 1, 32'h11112222};
        vecs[5]  = '{RW_READ,  32'h104, 32'h0,          4'h0, 1, 0, 32'h11112222};
        vecs[6]  = '{RW_WRITE, 32'h104, 32'h12345678,   4'b0011, 2, 2, 32'h0};
        vecs[7]  = '{RW_READ,  32'h104, 32'h0,          4'h0, 1, 1, 32'h11115678};
        vecs[8]  = '{RW_READ,  32'h107, 32'h0,          4'h0, 1, 0, 32'h11115678};
        vecs[9]  = '{RW_WRITE, 32'h304, 32'hAAAA5555,   4'hF, 3, 2, 32'h0};
        vecs[10] = '{RW_READ,  32'h104, 32'h0,          4'h0, 1, 0, 32'h11115678};

        mem_arr[32'h100] = 32'hDEADBEEF;
        mem_arr[32'h200] = 32'hCAFE0200;
        mem_arr[32'h104] = 32'h11112222;

        rst = 1'b1;
        cpu_rw_flag_i = RW_IDLE; cpu_addr_i = 0; cpu_w_data_i = 0; cpu_w_mask_i = 0;
        mem_r_data_i = 0; mem_busy_i = 0; mem_done_i = 0;
        repeat (3) @(negedge clk);
        check("reset cpu_done", 32'(cpu_done_o), 0);
        check("reset cpu_busy", 32'(cpu_busy_o), 0);
        check("reset mem_rw_flag", 32'(mem_rw_flag_o), 0);
        check("reset mem_addr", mem_addr_o, 0);
        check("reset cpu_r_data", cpu_r_data_o, 0);
        rst = 1'b0;

        // Directed table: fill, hit, conflict eviction, write-through with invalidate.
        for (int i = 0; i < 11; i++)
            do_and_check($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                         vecs[i].mask, vecs[i].lat, vecs[i].exp_mem, vecs[i].exp_data);

        // Reset two cycles into a miss: outputs drop at once, no done, cache emptied.
        @(negedge clk);
        cpu_rw_flag_i = RW_READ; cpu_addr_i = 32'h340;
        @(negedge clk);
        @(negedge clk);
        check("miss in flight busy", 32'(cpu_busy_o), 1);
        rst = 1'b1;
        #1;
        check("async rst mem_rw_flag", 32'(mem_rw_flag_o), 0);
        check("async rst cpu_busy", 32'(cpu_busy_o), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_done_o) bad++;
        end
        cpu_rw_flag_i = RW_IDLE;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (cpu_done_o) bad++;
        end
        check("no done after abandoned miss", bad, 0);
        do_and_check("post-reset 0x100", RW_READ, 32'h100, 0, 0, 2, 1, 32'hDEADBEEF);

        // Request held through RESP: one done per acceptance, never back-to-back.
        @(negedge clk);
        cpu_rw_flag_i = RW_READ; cpu_addr_i = 32'h100;
        pulses = 0; prev = 0; consec = 0; bad = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (cpu_done_o) begin
                pulses++;
                if (prev != 0) consec = 1;
                if (cpu_r_data_o != 32'hDEADBEEF) bad++;
            end
            if (mem_rw_flag_o != RW_IDLE) bad++;
            prev = int'(cpu_done_o);
        end
        cpu_rw_flag_i = RW_IDLE;
        check("held request done pulses", pulses, 3);
        check("held request back-to-back done", 32'(consec), 0);
        check("held request data/no traffic", bad, 0);
        do_and_check("0x108 miss", RW_READ, 32'h108, 0, 0, 2, 1, mem_read(32'h108));
        do_and_check("0x108 hit", RW_READ, 32'h108, 0, 0, 1, 0, mem_read(32'h108));

        // Flag 11 is idle; a stray mem_done while idle is ignored.
        @(negedge clk);
        cpu_rw_flag_i = 2'b11; cpu_addr_i = 32'h200;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            mem_done_i = (k == 4);
            mem_r_data_i = (k == 4) ? 32'h0BAD_0BAD : 32'h0;
            if (mem_rw_flag_o != RW_IDLE || cpu_busy_o || cpu_done_o) bad++;
        end
        mem_done_i = 1'b0;
        cpu_rw_flag_i = RW_IDLE;
        check("flag 11 idle behaviour", bad, 0);

        // Random traffic against an abstract model: a line holds tag for idx until replaced
        // by a miss fill or dropped by a write to the same address line.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, d, exp;
            logic [3:0] m;
            int idx, lat, em;
            logic [23:0] tg;
            bit is_wr, model_hit;
            a = 32'h0001_0000 + ($urandom_range(0, 2) * 256) + ($urandom_range(0, 3) * 4)
                + $urandom_range(0, 3);
            d = $urandom;
            m = 4'($urandom);
            lat = $urandom_range(1, 4);
            is_wr = ($urandom_range(0, 9) < 3);
            idx = int'(a[7:2]);
            tg = a[31:8];
            model_hit = mv.exists(idx) && mv[idx] && (mt[idx] == tg);
            if (is_wr) begin
                em = 2; exp = 32'h0;
                if (model_hit) mv[idx] = 0;
                do_and_check($sformatf("rnd%0d wr", n), RW_WRITE, a, d, m, lat, em, exp);
            end else begin
                em = model_hit ? 0 : 1;
                exp = mem_read(a);
                mv[idx] = 1; mt[idx] = tg;
                do_and_check($sformatf("rnd%0d rd", n), RW_READ, a, 0, 0, lat, em, exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
